// File: rtl/mvd_pingpong_buf_if.sv
// Bundle of write-side, read-side and status signals of the MVD ping-pong buffer.
// The slave modport is the buffer itself; the master modport is the producer/consumer side.
// Signal names carry the direction they have at the buffer (_i into it, _o out of it).
interface mvd_pingpong_buf_if #(
  parameter int MVD_W = 11,
  parameter int AW    = 6
);
  localparam int DW = 2*MVD_W + 1;

  // write side (MC/MVD stage)
  logic          mvd_wen_i;
  logic [AW-1:0] mvd_waddr_i;
  logic [DW-1:0] mvd_wdata_i;
  logic          wr_done_i;
  logic          wr_ready_o;

  // read side (entropy-coding stage)
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_done_i;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_hit_o;

  // sticky error status
  logic          err_ovf_o;
  logic          err_udf_o;

  modport master (
    output mvd_wen_i, mvd_waddr_i, mvd_wdata_i, wr_done_i,
    output rd_en_i, rd_addr_i, rd_done_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, rd_hit_o,
    input  err_ovf_o, err_udf_o
  );

  modport slave (
    input  mvd_wen_i, mvd_waddr_i, mvd_wdata_i, wr_done_i,
    input  rd_en_i, rd_addr_i, rd_done_i,
    output wr_ready_o, rd_valid_o, rd_data_o, rd_hit_o,
    output err_ovf_o, err_udf_o
  );
endinterface

// File: rtl/mvd_pingpong_buf.sv
// Two-bank ping-pong store of per-PU MVD/mvp entries between the MVD and entropy-coding stages.
// Latency: read data and hit flag registered, valid exactly 1 cycle after rd_en_i.
// Backpressure: wr_ready_o low when both banks are full (writes dropped); rd_valid_o low when none is.
module mvd_pingpong_buf #(
  parameter int MVD_W = 11,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                rstn,   // asynchronous, active-high
  mvd_pingpong_buf_if.slave   bus
);

  localparam int DW    = 2*MVD_W + 1;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                      r_wp;          // bank currently being filled
  logic                      r_rp;          // bank currently being drained
  logic [1:0]                r_cnt;         // number of full banks, 0..2
  logic [1:0][DEPTH-1:0]     r_vld;         // per-bank, per-entry written flags
  logic [DW-1:0]             r_mem [2][DEPTH];
  logic [DW-1:0]             r_rd_data;
  logic                      r_rd_hit;
  logic                      r_ovf;
  logic                      r_udf;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  logic                      w_full;
  logic                      w_empty;
  logic                      w_wr_acc;      // entry write accepted
  logic                      w_wdone_acc;   // bank completion accepted
  logic                      w_rdone_acc;   // bank release accepted
  logic                      w_ovf_evt;
  logic                      w_udf_evt;
  logic                      w_wp_nxt;
  logic                      w_rp_nxt;
  logic [1:0]                w_cnt_nxt;
  logic [1:0][DEPTH-1:0]     w_vld_nxt;
  logic [DW-1:0]             w_rd_data_nxt;
  logic                      w_rd_hit_nxt;

  // Accept/reject decisions all use the pre-edge count, so a completion and a
  // release in the same cycle are judged independently: at cnt==2 only the
  // release is honoured, at cnt==0 only the completion.
  always_comb begin
    w_full      = (r_cnt == 2'd2);
    w_empty     = (r_cnt == 2'd0);
    w_wr_acc    = bus.mvd_wen_i & ~w_full;
    w_wdone_acc = bus.wr_done_i & ~w_full;
    w_rdone_acc = bus.rd_done_i & ~w_empty;
    w_ovf_evt   = bus.wr_done_i &  w_full;
    w_udf_evt   = bus.rd_done_i &  w_empty;
  end

  // Pointer and fill-count update; simultaneous completion and release nets to zero.
  always_comb begin
    w_wp_nxt  = r_wp ^ w_wdone_acc;
    w_rp_nxt  = r_rp ^ w_rdone_acc;
    w_cnt_nxt = r_cnt;
    case ({w_wdone_acc, w_rdone_acc})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Valid-bit update: release clears the whole drained bank, then an accepted
  // write sets its entry, so a write into that same bank would win.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_rdone_acc) begin
      w_vld_nxt[r_rp] = '0;
    end
    if (w_wr_acc) begin
      w_vld_nxt[r_wp][bus.mvd_waddr_i] = 1'b1;
    end
  end

  // Read path: sample the drained bank, or return zeros when nothing is full;
  // outputs hold when no read is requested.
  always_comb begin
    w_rd_data_nxt = r_rd_data;
    w_rd_hit_nxt  = r_rd_hit;
    if (bus.rd_en_i) begin
      if (w_empty) begin
        w_rd_data_nxt = '0;
        w_rd_hit_nxt  = 1'b0;
      end else begin
        w_rd_data_nxt = r_mem[r_rp][bus.rd_addr_i];
        w_rd_hit_nxt  = r_vld[r_rp][bus.rd_addr_i];
      end
    end
  end

  // Control, valid bits, read register and sticky flags; reset discards all banks at once.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
      r_vld     <= '0;
      r_rd_data <= '0;
      r_rd_hit  <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_wp      <= w_wp_nxt;
      r_rp      <= w_rp_nxt;
      r_cnt     <= w_cnt_nxt;
      r_vld     <= w_vld_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_rd_hit  <= w_rd_hit_nxt;
      r_ovf     <= r_ovf | w_ovf_evt;
      r_udf     <= r_udf | w_udf_evt;
    end
  end

  // Entry storage has no reset so it can map onto a dual-port RAM; the read
  // register above sees the pre-write contents (read-before-write).
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp][bus.mvd_waddr_i] <= bus.mvd_wdata_i;
    end
  end

  // Status outputs straight from registered state.
  assign bus.wr_ready_o = ~w_full;
  assign bus.rd_valid_o = ~w_empty;
  assign bus.rd_data_o  = r_rd_data;
  assign bus.rd_hit_o   = r_rd_hit;
  assign bus.err_ovf_o  = r_ovf;
  assign bus.err_udf_o  = r_udf;

endmodule

// File: tb/tb_mvd_pingpong_buf.sv
// Bench for mvd_pingpong_buf: directed vector table, hand-written multi-cycle
// sequences (full LCU fill, asynchronous mid-LCU reset) and a randomized run
// checked against an LCU-queue reference model.
module tb_mvd_pingpong_buf;

  localparam int MVD_W = 11;
  localparam int AW    = 6;
  localparam int DW    = 2*MVD_W + 1;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mvd_pingpong_buf_if #(.MVD_W(MVD_W), .AW(AW)) bus ();

  mvd_pingpong_buf #(.MVD_W(MVD_W), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- checks
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_rdy, input logic e_vld, input logic dk,
                         input logic [DW-1:0] e_d, input logic e_h, input logic e_o, input logic e_u);
    chk1({tag, ".wr_ready"}, bus.wr_ready_o, e_rdy);
    chk1({tag, ".rd_valid"}, bus.rd_valid_o, e_vld);
    chk1({tag, ".rd_hit"},   bus.rd_hit_o,   e_h);
    chk1({tag, ".err_ovf"},  bus.err_ovf_o,  e_o);
    chk1({tag, ".err_udf"},  bus.err_udf_o,  e_u);
    if (dk) chkd({tag, ".rd_data"}, bus.rd_data_o, e_d);
  endtask

  // ---------------------------------------------------------------- drive
  task automatic drive(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic wdn, input logic ren, input logic [AW-1:0] ra, input logic rdn);
    bus.mvd_wen_i   = wen;
    bus.mvd_waddr_i = wa;
    bus.mvd_wdata_i = wd;
    bus.wr_done_i   = wdn;
    bus.rd_en_i     = ren;
    bus.rd_addr_i   = ra;
    bus.rd_done_i   = rdn;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic          wen;  logic [AW-1:0] wa;  logic [DW-1:0] wd;  logic wdn;
    logic          ren;  logic [AW-1:0] ra;  logic rdn;
    logic          e_rdy; logic e_vld; logic dk; logic [DW-1:0] e_d;
    logic          e_h;  logic e_o;  logic e_u;
  } vec_t;

  function automatic vec_t mk(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic wdn, input logic ren, input logic [AW-1:0] ra,
                              input logic rdn, input logic e_rdy, input logic e_vld,
                              input logic dk, input logic [DW-1:0] e_d, input logic e_h,
                              input logic e_o, input logic e_u);
    vec_t v;
    v.wen = wen; v.wa = wa; v.wd = wd; v.wdn = wdn;
    v.ren = ren; v.ra = ra; v.rdn = rdn;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.dk = dk; v.e_d = e_d;
    v.e_h = e_h; v.e_o = e_o; v.e_u = e_u;
    return v;
  endfunction

  localparam int NTBL = 24;
  vec_t tbl [NTBL];

  // ---------------------------------------------------------------- reference model
  // The buffer behaves as a FIFO of at most two completed LCUs plus one LCU
  // being assembled; reads look at the oldest completed LCU.
  typedef struct packed {
    logic [DEPTH-1:0][DW-1:0] d;
    logic [DEPTH-1:0]         v;
  } lcu_t;

  lcu_t          m_q[$];
  lcu_t          m_fill;
  logic [DW-1:0] m_d;
  logic          m_h, m_dk, m_ovf, m_udf;

  task automatic model_reset();
    m_q.delete();
    m_fill.v = '0;
    m_d = '0; m_h = 1'b0; m_dk = 1'b1;
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic wdn, input logic ren, input logic [AW-1:0] ra,
                            input logic rdn);
    int sz;
    sz = m_q.size();
    if (ren) begin
      if (sz == 0) begin
        m_d = '0; m_h = 1'b0; m_dk = 1'b1;
      end else begin
        m_h  = m_q[0].v[ra];
        m_d  = m_q[0].d[ra];
        m_dk = m_h;            // unwritten entries return stale, unpredictable data
      end
    end
    if (wen && sz < 2) begin
      m_fill.d[wa] = wd;
      m_fill.v[wa] = 1'b1;
    end
    if (wdn && sz == 2) m_ovf = 1'b1;
    if (rdn && sz == 0) m_udf = 1'b1;
    if (rdn && sz > 0) void'(m_q.pop_front());
    if (wdn && sz < 2) begin
      m_q.push_back(m_fill);
      m_fill.v = '0;
    end
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic          s_wen, s_wdn, s_ren, s_rdn;
    logic [AW-1:0] s_wa, s_ra;
    logic [DW-1:0] s_wd;

    rstn = 1'b1;
    idle();

    // reset state
    do_reset();
    chk_out("reset", 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);

    // directed table: empty read, underflow, sparse bank, overwrite, drop,
    // overflow, simultaneous done pulses at cnt 2/1/0, stale-data after release
    tbl[0]  = mk(0, 0, 0,         0, 1, 10, 0,  1, 0, 1, 0,         0, 0, 0);
    tbl[1]  = mk(0, 0, 0,         0, 0, 0,  1,  1, 0, 1, 0,         0, 0, 1);
    tbl[2]  = mk(1, 3, 'h1ABCDE,  0, 0, 0,  0,  1, 0, 1, 0,         0, 0, 1);
    tbl[3]  = mk(0, 0, 0,         1, 0, 0,  0,  1, 1, 1, 0,         0, 0, 1);
    tbl[4]  = mk(0, 0, 0,         0, 1, 4,  0,  1, 1, 0, 0,         0, 0, 1);
    tbl[5]  = mk(0, 0, 0,         0, 1, 3,  0,  1, 1, 1, 'h1ABCDE,  1, 0, 1);
    tbl[6]  = mk(0, 0, 0,         0, 0, 0,  0,  1, 1, 1, 'h1ABCDE,  1, 0, 1);
    tbl[7]  = mk(1, 7, 'h111,     0, 0, 0,  0,  1, 1, 1, 'h1ABCDE,  1, 0, 1);
    tbl[8]  = mk(1, 7, 'h222,     0, 0, 0,  0,  1, 1, 1, 'h1ABCDE,  1, 0, 1);
    tbl[9]  = mk(0, 0, 0,         1, 0, 0,  0,  0, 1, 1, 'h1ABCDE,  1, 0, 1);
    tbl[10] = mk(1, 0, 'h7,       0, 0, 0,  0,  0, 1, 1, 'h1ABCDE,  1, 0, 1);
    tbl[11] = mk(0, 0, 0,         1, 0, 0,  0,  0, 1, 1, 'h1ABCDE,  1, 1, 1);
    tbl[12] = mk(0, 0, 0,         0, 1, 3,  0,  0, 1, 1, 'h1ABCDE,  1, 1, 1);
    tbl[13] = mk(0, 0, 0,         1, 0, 0,  1,  1, 1, 1, 'h1ABCDE,  1, 1, 1);
    tbl[14] = mk(0, 0, 0,         0, 1, 7,  0,  1, 1, 1, 'h222,     1, 1, 1);
    tbl[15] = mk(0, 0, 0,         0, 1, 0,  0,  1, 1, 0, 0,         0, 1, 1);
    tbl[16] = mk(1, 9, 'h99,      0, 0, 0,  0,  1, 1, 0, 0,         0, 1, 1);
    tbl[17] = mk(0, 0, 0,         1, 0, 0,  1,  1, 1, 0, 0,         0, 1, 1);
    tbl[18] = mk(0, 0, 0,         0, 1, 9,  0,  1, 1, 1, 'h99,      1, 1, 1);
    tbl[19] = mk(0, 0, 0,         0, 1, 3,  0,  1, 1, 1, 'h1ABCDE,  0, 1, 1);
    tbl[20] = mk(0, 0, 0,         0, 0, 0,  1,  1, 0, 1, 'h1ABCDE,  0, 1, 1);
    tbl[21] = mk(0, 0, 0,         0, 1, 3,  0,  1, 0, 1, 0,         0, 1, 1);
    tbl[22] = mk(0, 0, 0,         1, 0, 0,  1,  1, 1, 1, 0,         0, 1, 1);
    tbl[23] = mk(0, 0, 0,         0, 1, 7,  0,  1, 1, 1, 'h222,     0, 1, 1);

    for (int i = 0; i < NTBL; i++) begin
      drive(tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].wdn, tbl[i].ren, tbl[i].ra, tbl[i].rdn);
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].dk,
              tbl[i].e_d, tbl[i].e_h, tbl[i].e_o, tbl[i].e_u);
    end

    // full LCU: every address written with its own index, then spot reads
    do_reset();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, AW'(a), DW'(a), 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    chk1("fill.rd_valid_before_done", bus.rd_valid_o, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    chk_out("fill.done", 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, AW'(5), 1'b0);
    tick();
    chk_out("fill.rd5", 1'b1, 1'b1, 1'b1, DW'(5), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, AW'(63), 1'b0);
    tick();
    chk_out("fill.rd63", 1'b1, 1'b1, 1'b1, DW'(63), 1'b1, 1'b0, 1'b0);

    // second bank fills up, extra completion overflows, then async reset mid-cycle
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, AW'(a), DW'(32'h100 + a), 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    chk_out("both_full", 1'b0, 1'b1, 1'b1, DW'(63), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1, AW'(5), 1'b0);
    tick();
    chk_out("ovf_rd5", 1'b0, 1'b1, 1'b1, DW'(5), 1'b1, 1'b1, 1'b0);
    idle();
    #2;
    rstn = 1'b1;
    #1;
    chk_out("async_rst", 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    tick();
    rstn = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1, AW'(5), 1'b0);
    tick();
    chk_out("post_rst_rd", 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);

    // randomized traffic against the LCU-queue model, several epochs from reset
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
        s_wen = ($urandom_range(0, 1) == 1);
        s_wa  = AW'($urandom_range(0, 15));
        s_wd  = DW'($urandom);
        s_wdn = ($urandom_range(0, 5) == 0);
        s_ren = ($urandom_range(0, 1) == 1);
        s_ra  = AW'($urandom_range(0, 15));
        s_rdn = ($urandom_range(0, 5) == 0);
        drive(s_wen, s_wa, s_wd, s_wdn, s_ren, s_ra, s_rdn);
        model_step(s_wen, s_wa, s_wd, s_wdn, s_ren, s_ra, s_rdn);
        tick();
        chk_out($sformatf("rnd%0d_%0d", ep, c), (m_q.size() < 2), (m_q.size() > 0),
                m_dk, m_d, m_h, m_ovf, m_udf);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mvd_pingpong_buf.md
MVD_PINGPONG_BUF -- requirements
Module: mvd_pingpong_buf

Interface
REQ-001 SHALL have parameter MVD_W, default 11: width of one MVD component; entry width DW = 2*MVD_W+1 (mvp_idx bit + mvd_y + mvd_x).
REQ-002 SHALL have parameter AW, default 6: entry address width; each bank holds 2^AW = 64 entries, one per 8x8 PU of a 64x64 LCU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous reset, active-high (1 = reset asserted), applied without waiting for clk.
REQ-005 mvd_wen_i  input  1  write strobe, active-high, from MC/MVD stage.
REQ-006 mvd_waddr_i  input  AW  write entry address.
REQ-007 mvd_wdata_i  input  DW  MVD and mvp index write data.
REQ-008 wr_done_i  input  1  one-cycle pulse: the current write bank holds a complete LCU.
REQ-009 wr_ready_o  output  1  a free bank is available for writing.
REQ-010 rd_en_i  input  1  read strobe from the entropy-coding stage.
REQ-011 rd_addr_i  input  AW  read entry address.
REQ-012 rd_done_i  input  1  one-cycle pulse: the current read bank is released.
REQ-013 rd_valid_o  output  1  a full bank is available for reading.
REQ-014 rd_data_o  output  DW  read data.
REQ-015 rd_hit_o  output  1  the entry returned on rd_data_o was written since that bank was last released.
REQ-016 err_ovf_o  output  1  sticky flag: wr_done_i received while both banks were full.
REQ-017 err_udf_o  output  1  sticky flag: rd_done_i received while no bank was full.

Function
REQ-018 SHALL hold two banks of 64 x DW storage, one per-entry valid bit per bank, a write bank pointer wp, a read bank pointer rp, and a full count cnt in 0..2.
REQ-019 wr_ready_o SHALL equal (cnt<2); rd_valid_o SHALL equal (cnt>0); both are combinational from registered state.
REQ-020 mvd_wen_i=1 with cnt<2 SHALL write mvd_wdata_i to bank wp at mvd_waddr_i and set that entry's valid bit on the same edge.
REQ-021 mvd_wen_i=1 with cnt==2 SHALL be dropped: no storage change, no flag set.
REQ-022 Repeated writes to the same address before wr_done_i SHALL leave the last written value stored.
REQ-023 wr_done_i with cnt<2 SHALL toggle wp and increment cnt; wr_done_i with cnt==2 SHALL leave wp and cnt unchanged and set err_ovf_o.
REQ-024 rd_en_i SHALL give read latency of exactly 1 cycle: on the next cycle rd_data_o = bank rp[rd_addr_i] and rd_hit_o = that entry's valid bit, both registered.
REQ-025 If cnt==0 when rd_en_i is sampled, the next cycle SHALL have rd_data_o=0 and rd_hit_o=0.
REQ-026 Without rd_en_i, rd_data_o and rd_hit_o SHALL hold their previous values.
REQ-027 rd_done_i with cnt>0 SHALL toggle rp, decrement cnt, and clear all 64 valid bits of the released bank in that cycle; stored data is not cleared.
REQ-028 rd_done_i with cnt==0 SHALL leave rp and cnt unchanged and set err_udf_o.
REQ-029 wr_done_i and rd_done_i in the same cycle with cnt==1 SHALL toggle both wp and rp and leave cnt=1.
REQ-030 wr_done_i and rd_done_i in the same cycle with cnt==2 SHALL perform the release; the wr_done_i SHALL be treated as overflow (err_ovf_o set; wp and cnt follow the release only).
REQ-031 wr_done_i and rd_done_i in the same cycle with cnt==0 SHALL perform the write completion and SHALL set err_udf_o.
REQ-032 A write and a read to the same bank, same address, in the same cycle SHALL return the old data (read-before-write); this cannot occur legally but is defined.
REQ-033 The valid-bit clear of REQ-027 and a same-cycle write into the released bank (cnt==2 to 1 while wp==released bank is impossible) SHALL NOT be reachable; when wp equals the released bank, write priority SHALL apply to that entry.
REQ-034 Storage SHALL be implementable as register arrays or dual-port RAM with the REQ-024 latency; valid bits SHALL be flops.

Reset
REQ-035 While rstn=1: wp=0, rp=0, cnt=0, all valid bits 0, rd_data_o=0, rd_hit_o=0, err_ovf_o=0, err_udf_o=0; hence wr_ready_o=1 and rd_valid_o=0.
REQ-036 Reset asserted mid-operation SHALL discard all banks immediately; bank data contents are don't-care after reset.
REQ-037 Error flags SHALL clear only by reset.

Verification
REQ-038 Basic: after reset, write addr 0..63 with data=addr, pulse wr_done_i -> rd_valid_o=1; read addr 5 -> next cycle rd_data_o=5, rd_hit_o=1.
REQ-039 Sparse: write only addr 3 (0x1ABCDE), wr_done_i, read addr 4 -> rd_hit_o=0; read addr 3 -> 0x1ABCDE, rd_hit_o=1.
REQ-040 Ping-pong: fill bank0 and bank1 (cnt=2) -> wr_ready_o=0; write addr 0 data 0x7 is dropped; third wr_done_i -> err_ovf_o=1, cnt remains 2.
REQ-041 Simultaneous: with cnt=1, wr_done_i and rd_done_i pulsed together -> cnt=1, wp=0, rp=1, reading bank1 returns its written data.
REQ-042 Underflow/empty: after reset, rd_en_i addr 10 -> rd_data_o=0, rd_hit_o=0; rd_done_i -> err_udf_o=1, rd_valid_o=0.
REQ-043 Reset mid-LCU: with cnt=2, assert rstn asynchronously between clock edges -> all outputs at REQ-035 values before the next edge.
